multdiv_seq: RTL and testbench

MULTDIV_SEQ -- requirements
Module: multdiv_seq

---
 rtl/multdiv_seq.sv | 99 +++++++++
 tb/tb_multdiv_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_seq.sv
// Sequencer for an iterative multiply/divide engine: LOAD, STEPS x RUN, HI/LO writeback, done.
// Define MULTDIV_DIVZERO_TRAP_EN to divert div-by-zero to a one-cycle EXC state instead of running it.
module multdiv_seq #(
  parameter int STEPS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] divisor,
  output logic        eng_load,
  output logic        eng_step,
  output logic        eng_mode,
  output logic        hilo_write,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_WB,
    S_DONE,
    S_EXC
  } state_e;

  localparam logic [5:0] LAST_STEP = 6'(STEPS - 1);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       mode_q, mode_d;
  logic       div_trap;

`ifdef MULTDIV_DIVZERO_TRAP_EN
  assign div_trap = op && (divisor == '0);
`else
  // Without the trap the divisor value never influences sequencing.
  logic unused_divisor;
  assign unused_divisor = ^divisor;
  assign div_trap       = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = op;
          state_d = div_trap ? S_EXC : S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // Final value is STEPS, at most 63, so the 6-bit counter never wraps.
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_STEP) state_d = S_WB;
      end
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_EXC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign eng_load   = (state_q == S_LOAD);
  assign eng_step   = (state_q == S_RUN);
  assign hilo_write = (state_q == S_WB);
  assign done       = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign eng_mode   = mode_q;

`ifdef MULTDIV_DIVZERO_TRAP_EN
  assign div_zero = (state_q == S_EXC);
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_multdiv_seq.sv
// Randomized self-checking bench for multdiv_seq: one instance with STEPS=32, one with STEPS=1,
// compared cycle by cycle against a latency-table model of the output strobes.
module tb_multdiv_seq;

`ifdef MULTDIV_DIVZERO_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic        op;
  logic [31:0] divisor;

  logic a_load, a_step, a_mode, a_wb, a_busy, a_done, a_dz;
  logic b_load, b_step, b_mode, b_wb, b_busy, b_done, b_dz;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  multdiv_seq #(.STEPS(32)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .op(op), .divisor(divisor),
    .eng_load(a_load), .eng_step(a_step), .eng_mode(a_mode), .hilo_write(a_wb),
    .busy(a_busy), .done(a_done), .div_zero(a_dz)
  );

  multdiv_seq #(.STEPS(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .op(op), .divisor(divisor),
    .eng_load(b_load), .eng_step(b_step), .eng_mode(b_mode), .hilo_write(b_wb),
    .busy(b_busy), .done(b_done), .div_zero(b_dz)
  );

  // Bit order: {busy, eng_load, eng_step, hilo_write, done, div_zero, eng_mode}
  function automatic logic [6:0] observe(input int sel);
    if (sel == 0) return {a_busy, a_load, a_step, a_wb, a_done, a_dz, a_mode};
    return {b_busy, b_load, b_step, b_wb, b_done, b_dz, b_mode};
  endfunction

  // Expected outputs k cycles after the edge that accepted start.
  function automatic logic [6:0] exp_out(input int k, input int steps, input bit op_i, input bit dz);
    logic bsy, ld, st, wb, dn, z;
    bsy = 0; ld = 0; st = 0; wb = 0; dn = 0; z = 0;
    if (TRAP && op_i && dz) begin
      bsy = (k == 1);
      z   = (k == 1);
    end else begin
      bsy = (k >= 1) && (k <= steps + 3);
      ld  = (k == 1);
      st  = (k >= 2) && (k <= steps + 1);
      wb  = (k == steps + 2);
      dn  = (k == steps + 3);
    end
    return {bsy, ld, st, wb, dn, z, op_i};
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start_a = v;
    else          start_b = v;
  endtask

  // Starts one op from a negedge with the DUT idle; ends on the negedge of the first idle cycle.
  task automatic run_op(input int sel, input bit op_i, input logic [31:0] div_i,
                        input bit noise, input int pulse_at, input string name);
    int steps;
    int span;
    logic [6:0] obs, exp;
    steps   = (sel == 0) ? 32 : 1;
    span    = (TRAP && op_i && div_i == 0) ? 1 : steps + 3;
    op      = op_i;
    divisor = div_i;
    set_start(sel, 1'b1);
    for (int k = 1; k <= span + 1; k++) begin
      @(negedge clk);
      obs = observe(sel);
      exp = exp_out(k, steps, op_i, div_i == 0);
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, k, obs, exp);
      end
      set_start(sel, 1'b0);
      if (k == pulse_at) begin
        op = 1'b0;
        set_start(sel, 1'b1);
      end else if (noise && k <= span - 1) begin
        op      = 1'($urandom);
        divisor = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        set_start(sel, 1'($urandom));
      end
    end
    set_start(sel, 1'b0);
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    start_a = 1'b1;
    start_b = 1'b1;
    op      = 1'b1;
    divisor = 32'd0;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if ({observe(0), observe(1)} !== 14'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got %b_%b expected all zero", observe(0), observe(1));
    end
    reset   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({observe(0), observe(1)} !== 14'd0) begin
      tests_failed++;
      $display("FAIL reset_priority: got %b_%b expected all zero", observe(0), observe(1));
    end
  endtask

  task automatic test_mult();
    run_op(0, 1'b0, $urandom, 1'b0, 0, "mult_steps32");
    run_op(0, 1'b1, 32'd7 + $urandom_range(0, 1000), 1'b0, 0, "div_steps32");
  endtask

  task automatic test_steps1();
    run_op(1, 1'b0, $urandom, 1'b0, 0, "mult_steps1");
    run_op(1, 1'b1, 32'd3, 1'b0, 0, "div_steps1");
  endtask

  task automatic test_div_zero();
    run_op(0, 1'b1, 32'd0, 1'b0, 0, "divzero_steps32");
    run_op(1, 1'b1, 32'd0, 1'b0, 0, "divzero_steps1");
    run_op(0, 1'b0, 32'd0, 1'b0, 0, "mult_zero_b");
  endtask

  task automatic test_ignored_start();
    run_op(0, 1'b1, 32'd9, 1'b0, 5, "ignored_start");
    run_op(0, 1'b0, 32'd5, 1'b1, 0, "busy_noise");
  endtask

  task automatic test_reset_mid_run();
    logic [6:0] obs;
    op      = 1'b1;
    divisor = 32'd7;
    start_a = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    tests_run++;
    if (a_step !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_run_step: got %b expected 1", a_step);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (observe(0) !== 7'd0) begin
      tests_failed++;
      $display("FAIL mid_run_reset: got %b expected 0000000", observe(0));
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      obs = observe(0);
      tests_run++;
      if (obs !== 7'd0) begin
        tests_failed++;
        $display("FAIL after_abort cycle %0d: got %b expected 0000000", k, obs);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit          o;
    logic [31:0] d;
    for (int i = 0; i < 6; i++) begin
      o = 1'($urandom);
      d = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
      run_op(0, o, d, 1'b1, 0, "b2b_steps32");
    end
    for (int i = 0; i < 8; i++) begin
      o = 1'($urandom);
      d = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
      run_op(1, o, d, 1'b1, 0, "b2b_steps1");
    end
  endtask

  initial begin
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    op      = 1'b0;
    divisor = 32'd0;
    @(negedge clk);
    test_reset();
    test_mult();
    test_steps1();
    test_div_zero();
    test_ignored_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
